irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller_pkg.sv | 41 ++++
 rtl/irq_controller_prio_enc.sv | 21 ++
 rtl/irq_controller.sv | 111 +++++++++++
 tb/tb_irq_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared io offsets, source indices and helpers for the irq controller
package irq_controller_pkg;

  localparam int          IRQ_NUM_SRC  = 14;
  localparam logic [11:0] IO_IE_IF_OFF = 12'h200;
  localparam logic [11:0] IO_IME_OFF   = 12'h208;
  localparam logic [3:0]  IRQ_NONE     = 4'hf;

  localparam int IRQ_VBLANK  = 0;
  localparam int IRQ_HBLANK  = 1;
  localparam int IRQ_VCOUNT  = 2;
  localparam int IRQ_TIMER0  = 3;
  localparam int IRQ_TIMER1  = 4;
  localparam int IRQ_TIMER2  = 5;
  localparam int IRQ_TIMER3  = 6;
  localparam int IRQ_SERIAL  = 7;
  localparam int IRQ_DMA0    = 8;
  localparam int IRQ_DMA1    = 9;
  localparam int IRQ_DMA2    = 10;
  localparam int IRQ_DMA3    = 11;
  localparam int IRQ_KEYPAD  = 12;
  localparam int IRQ_GAMEPAK = 13;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10
  } acc_width_e;

  // Byte-lane write mask for an access of the given size at byte offset off.
  function automatic logic [31:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
    logic [31:0] m;
    case (width)
      2'b00:   m = 32'h0000_00ff;
      2'b01:   m = 32'h0000_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m << {off, 3'b000};
  endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// rtl/irq_controller_prio_enc.sv - lowest-set-bit priority encoder, bit 0 wins
module irq_prio_enc
  import irq_controller_pkg::*;
(
  input  logic [IRQ_NUM_SRC-1:0] i_vec,
  output logic [3:0]             o_idx,
  output logic                   o_valid
);

  always_comb begin
    o_idx   = IRQ_NONE;
    o_valid = 1'b0;
    for (int i = IRQ_NUM_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - IE/IF/IME interrupt controller with edge capture and ack
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = IO_IE_IF_OFF
) (
  input  logic        clk_mem,
  input  logic        rst_n,
  input  logic [23:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  width,
  input  logic [13:0] irq_src,
  input  logic        irq_ack,
  output logic        irq,
  output logic [3:0]  irq_id
);

  localparam logic [11:0] IME_ADDR = BASE_ADDR + (IO_IME_OFF - IO_IE_IF_OFF);

  logic [13:0] r_ie;
  logic [13:0] r_if;
  logic [13:0] r_src_q;
  logic        r_ime;
  logic        r_armed;
  logic        r_irq;
  logic [3:0]  r_irq_id;

  logic [31:0] w_mask;
  logic [31:0] w_wval;
  logic [31:0] w_word;
  logic        w_sel_ieif;
  logic        w_sel_ime;
  logic        w_wr_ieif;
  logic        w_wr_ime;
  logic [13:0] w_ie_next;
  logic [13:0] w_if_wclr;
  logic [13:0] w_ack_clr;
  logic [13:0] w_rise;
  logic [13:0] w_if_next;
  logic [13:0] w_pending;
  logic [3:0]  w_pend_idx;
  logic        w_pend_valid;
  logic        w_unused;

  assign w_mask     = lane_mask(width, addr[1:0]);
  assign w_wval     = data_in << {addr[1:0], 3'b000};
  assign w_sel_ieif = (addr[11:2] == BASE_ADDR[11:2]);
  assign w_sel_ime  = (addr[11:2] == IME_ADDR[11:2]);
  assign w_wr_ieif  = write & w_sel_ieif;
  assign w_wr_ime   = write & w_sel_ime;

  always_comb begin
    w_word = 32'h0;
    if (w_sel_ieif) begin
      w_word = {2'b00, r_if, 2'b00, r_ie};
    end else if (w_sel_ime) begin
      w_word = {31'h0, r_ime};
    end
  end

  assign data_out = w_word >> {addr[1:0], 3'b000};

  assign w_ie_next = (r_ie & ~w_mask[13:0]) | (w_wval[13:0] & w_mask[13:0]);
  assign w_if_wclr = w_wr_ieif ? (w_wval[29:16] & w_mask[29:16]) : 14'h0;
  assign w_ack_clr = (irq_ack && (r_irq_id != IRQ_NONE)) ? (14'h1 << r_irq_id) : 14'h0;

  // The first cycle after reset only primes the history, so levels already high are not edges.
  assign w_rise    = r_armed ? (irq_src & ~r_src_q) : 14'h0;
  assign w_if_next = (r_if & ~w_if_wclr & ~w_ack_clr) | w_rise;
  assign w_pending = r_ie & r_if;

  irq_prio_enc u_prio_enc (
    .i_vec   (w_pending),
    .o_idx   (w_pend_idx),
    .o_valid (w_pend_valid)
  );

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      r_ie     <= 14'h0;
      r_if     <= 14'h0;
      r_src_q  <= 14'h0;
      r_ime    <= 1'b0;
      r_armed  <= 1'b0;
      r_irq    <= 1'b0;
      r_irq_id <= IRQ_NONE;
    end else begin
      r_src_q  <= irq_src;
      r_armed  <= 1'b1;
      r_if     <= w_if_next;
      r_irq    <= r_ime & w_pend_valid;
      r_irq_id <= w_pend_idx;
      if (w_wr_ieif) begin
        r_ie <= w_ie_next;
      end
      if (w_wr_ime && w_mask[0]) begin
        r_ime <= w_wval[0];
      end
    end
  end

  assign irq    = r_irq;
  assign irq_id = r_irq_id;

  assign w_unused = ^{addr[23:12], read, w_mask[31:30], w_mask[15:14],
                      w_wval[31:30], w_wval[15:14]};

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller
module tb_irq_controller;

  logic        clk_mem = 1'b0;
  logic        rst_n;
  logic [23:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        read;
  logic        write;
  logic [1:0]  width;
  logic [13:0] irq_src;
  logic        irq_ack;
  logic        irq;
  logic [3:0]  irq_id;

  int n_checks = 0;
  int n_pass   = 0;

  string       sb_name[$];
  int          sb_kind[$];
  logic [31:0] sb_exp[$];

  irq_controller #(.BASE_ADDR(12'h200)) dut (
    .clk_mem  (clk_mem),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .read     (read),
    .write    (write),
    .width    (width),
    .irq_src  (irq_src),
    .irq_ack  (irq_ack),
    .irq      (irq),
    .irq_id   (irq_id)
  );

  always #5 clk_mem = ~clk_mem;

  // Monitor: kind 0 = data_out, 1 = irq, 2 = irq_id
  always @(negedge clk_mem) begin
    while (sb_kind.size() > 0) begin
      string       n;
      int          k;
      logic [31:0] e;
      logic [31:0] act;
      n = sb_name.pop_front();
      k = sb_kind.pop_front();
      e = sb_exp.pop_front();
      case (k)
        0:       act = data_out;
        1:       act = {31'h0, irq};
        default: act = {28'h0, irq_id};
      endcase
      n_checks++;
      if (act !== e) begin
        $display("FAIL %s: got %h expected %h", n, act, e);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic push(input string n, input int k, input logic [31:0] e);
    sb_name.push_back(n);
    sb_kind.push_back(k);
    sb_exp.push_back(e);
  endtask

  task automatic expect_rd(input string n, input logic [11:0] a, input logic [31:0] e);
    addr  = {12'h0, a};
    width = 2'b10;
    read  = 1'b1;
    push(n, 0, e);
  endtask

  task automatic expect_irq(input string n, input logic ei, input logic [3:0] eid);
    push({n, "_irq"}, 1, {31'h0, ei});
    push({n, "_id"}, 2, {28'h0, eid});
  endtask

  task automatic sample();
    @(negedge clk_mem);
    #1;
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_mem);
      #1;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] w);
    addr    = {12'h0, a};
    data_in = d;
    width   = w;
    write   = 1'b1;
    idle(1);
    write   = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    idle(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    addr    = 24'h0;
    data_in = 32'h0;
    read    = 1'b0;
    write   = 1'b0;
    width   = 2'b10;
    irq_src = 14'h0;
    irq_ack = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    expect_rd("rst_ieif", 12'h200, 32'h0);
    expect_irq("rst", 1'b0, 4'hf);
    sample();
    expect_rd("rst_ime", 12'h208, 32'h0);
    sample();

    // Single source, irq lags IF by one cycle
    wr(12'h200, 32'h0000_0008, 2'b10);
    wr(12'h208, 32'h0000_0001, 2'b10);
    irq_src = 14'h0008;
    idle(1);
    irq_src = 14'h0;
    expect_rd("t3_if_set", 12'h200, 32'h0008_0008);
    expect_irq("t3_lag", 1'b0, 4'hf);
    sample();
    idle(1);
    expect_irq("t3_irq", 1'b1, 4'd3);
    sample();
    ack();
    expect_rd("t3_ack_if", 12'h200, 32'h0000_0008);
    sample();
    idle(1);
    expect_irq("t3_after_ack", 1'b0, 4'hf);
    sample();

    // Two sources, priority then successive acks
    wr(12'h200, 32'h0000_3fff, 2'b10);
    irq_src = 14'h0220;
    idle(1);
    irq_src = 14'h0;
    idle(1);
    expect_irq("prio5", 1'b1, 4'd5);
    sample();
    ack();
    idle(1);
    expect_rd("ack5_if", 12'h200, 32'h0200_3fff);
    expect_irq("prio9", 1'b1, 4'd9);
    sample();
    ack();
    idle(1);
    expect_irq("ack9", 1'b0, 4'hf);
    sample();

    // Set wins over a same-cycle write-1-to-clear
    addr    = 24'h000202;
    data_in = 32'h0000_0008;
    width   = 2'b01;
    write   = 1'b1;
    irq_src = 14'h0008;
    idle(1);
    write   = 1'b0;
    irq_src = 14'h0;
    expect_rd("set_wins", 12'h200, 32'h0008_3fff);
    sample();
    wr(12'h202, 32'h0000_0008, 2'b01);
    expect_rd("w1c_half", 12'h200, 32'h0000_3fff);
    sample();

    // Ack and register write clear in the same cycle
    irq_src = 14'h0012;
    idle(1);
    irq_src = 14'h0;
    idle(1);
    expect_irq("prio1", 1'b1, 4'd1);
    sample();
    addr    = 24'h000202;
    data_in = 32'h0000_0010;
    width   = 2'b01;
    write   = 1'b1;
    irq_ack = 1'b1;
    idle(1);
    write   = 1'b0;
    irq_ack = 1'b0;
    expect_rd("ack_and_w1c", 12'h200, 32'h0000_3fff);
    sample();
    idle(1);
    expect_irq("ack_and_w1c", 1'b0, 4'hf);
    sample();

    // Byte write into lane 1, IME gating
    wr(12'h200, 32'h0, 2'b10);
    irq_src = 14'h0100;
    idle(1);
    irq_src = 14'h0;
    wr(12'h201, 32'h0000_0001, 2'b00);
    expect_rd("byte_ie", 12'h200, 32'h0100_0100);
    sample();
    wr(12'h208, 32'h0, 2'b10);
    idle(1);
    expect_irq("ime_off", 1'b0, 4'd8);
    expect_rd("ime_rd0", 12'h208, 32'h0);
    sample();
    expect_rd("rd_shift", 12'h202, 32'h0000_0100);
    sample();
    expect_rd("unmapped", 12'h204, 32'h0);
    sample();

    // Reset mid-operation, with a source held high through release
    wr(12'h208, 32'h0000_0001, 2'b10);
    idle(1);
    expect_irq("pre_rst", 1'b1, 4'd8);
    sample();
    irq_src = 14'h0001;
    rst_n   = 1'b0;
    expect_irq("in_rst", 1'b0, 4'hf);
    expect_rd("in_rst_ieif", 12'h200, 32'h0);
    sample();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    expect_rd("held_no_edge", 12'h200, 32'h0);
    sample();
    irq_src = 14'h0;
    idle(1);
    irq_src = 14'h0001;
    idle(1);
    expect_rd("held_reedge", 12'h200, 32'h0001_0000);
    sample();

    for (int i = 0; i < 10 && sb_kind.size() > 0; i++) begin
      @(negedge clk_mem);
    end
    if (sb_kind.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb_kind.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
